// File: rtl/exp4_pkg.sv
// Shared definitions for the Experiment 4 "sequence of plays" circuit:
// state codes of the control unit and their width.
package exp4_pkg;

   localparam int ESTADO_W = 4;

   typedef enum logic [ESTADO_W-1:0] {
      inicial     = 4'b0000,
      preparacao  = 4'b0001,
      espera      = 4'b0010,
      registra    = 4'b0100,
      comparacao  = 4'b0101,
      proximo     = 4'b0110,
      fim_acertou = 4'b1010,
      fim_errou   = 4'b1110
   } estado_t;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one pulse per low-to-high transition of sinal.
// A held input yields a single pulse; it must drop before the next one.
module edge_detector (
   input  logic clock,
   input  logic reset,
   input  logic sinal,
   output logic pulso
);

   logic r_anterior;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_anterior <= 1'b0;
      else       r_anterior <= sinal;
   end

   assign pulso = sinal & ~r_anterior;

endmodule

// File: rtl/unidade_controle.sv
// Moore control unit sequencing 16 button plays against memory contents.
// Drives the address counter and play register; reports success or failure.
//
// state       | meaning
// inicial     | idle, waiting for iniciar
// preparacao  | clear counter and play register
// espera      | waiting for a button press
// registra    | load the play register
// comparacao  | sample igual/fim against the stable registered play
// proximo     | advance the address counter
// fim_acertou | round over, all 16 plays correct
// fim_errou   | round over, a wrong play was made
module unidade_controle
   import exp4_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                iniciar,
   input  logic                jogada,
   input  logic                igual,
   input  logic                fim,
   output logic                zeraC,
   output logic                contaC,
   output logic                zeraR,
   output logic                registraR,
   output logic                pronto,
   output logic                acertou,
   output logic                errou,
   output logic [ESTADO_W-1:0] db_estado
);

   logic    w_jogada_pulso;
   estado_t w_estado_prox;
   estado_t r_estado;
   logic    r_zeraC, r_contaC, r_zeraR, r_registraR;
   logic    r_pronto, r_acertou, r_errou;

   edge_detector u_edge_detector (
      .clock (clock),
      .reset (reset),
      .sinal (jogada),
      .pulso (w_jogada_pulso)
   );

   always_comb begin
      w_estado_prox = inicial;
      case (r_estado)
         inicial:     w_estado_prox = iniciar ? preparacao : inicial;
         preparacao:  w_estado_prox = espera;
         espera:      w_estado_prox = w_jogada_pulso ? registra : espera;
         registra:    w_estado_prox = comparacao;
         comparacao: begin
            if (!igual)   w_estado_prox = fim_errou;
            else if (fim) w_estado_prox = fim_acertou;
            else          w_estado_prox = proximo;
         end
         proximo:     w_estado_prox = espera;
         fim_acertou: w_estado_prox = iniciar ? preparacao : fim_acertou;
         fim_errou:   w_estado_prox = iniciar ? preparacao : fim_errou;
         default:     w_estado_prox = inicial;
      endcase
   end

   // Outputs are registered from the next state so they stay a pure
   // function of the state register while avoiding decode glitches.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado    <= inicial;
         r_zeraC     <= 1'b0;
         r_contaC    <= 1'b0;
         r_zeraR     <= 1'b0;
         r_registraR <= 1'b0;
         r_pronto    <= 1'b0;
         r_acertou   <= 1'b0;
         r_errou     <= 1'b0;
      end else begin
         r_estado    <= w_estado_prox;
         r_zeraC     <= (w_estado_prox == preparacao);
         r_zeraR     <= (w_estado_prox == preparacao);
         r_contaC    <= (w_estado_prox == proximo);
         r_registraR <= (w_estado_prox == registra);
         r_pronto    <= (w_estado_prox == fim_acertou) || (w_estado_prox == fim_errou);
         r_acertou   <= (w_estado_prox == fim_acertou);
         r_errou     <= (w_estado_prox == fim_errou);
      end
   end

   assign zeraC     = r_zeraC;
   assign contaC    = r_contaC;
   assign zeraR     = r_zeraR;
   assign registraR = r_registraR;
   assign pronto    = r_pronto;
   assign acertou   = r_acertou;
   assign errou     = r_errou;
   assign db_estado = r_estado;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed self-checking bench for unidade_controle.
module tb_unidade_controle;
   import exp4_pkg::*;

   logic       clock, reset, iniciar, jogada, igual, fim;
   logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou;
   logic [3:0] db_estado;

   int n_checks = 0;
   int n_err    = 0;
   int n_conta  = 0;
   int n_reg    = 0;

   unidade_controle dut (
      .clock     (clock),
      .reset     (reset),
      .iniciar   (iniciar),
      .jogada    (jogada),
      .igual     (igual),
      .fim       (fim),
      .zeraC     (zeraC),
      .contaC    (contaC),
      .zeraR     (zeraR),
      .registraR (registraR),
      .pronto    (pronto),
      .acertou   (acertou),
      .errou     (errou),
      .db_estado (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected {zeraC, contaC, zeraR, registraR, pronto, acertou, errou} per state code.
   function automatic logic [6:0] saidas(input logic [3:0] code);
      case (code)
         4'b0001: saidas = 7'b1010000;
         4'b0100: saidas = 7'b0001000;
         4'b0110: saidas = 7'b0100000;
         4'b1010: saidas = 7'b0000110;
         4'b1110: saidas = 7'b0000101;
         default: saidas = 7'b0000000;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   task automatic chk_estado(input string tag, input logic [3:0] code);
      chk({tag, "_estado"}, {3'b000, db_estado}, {3'b000, code});
      chk({tag, "_saidas"}, {zeraC, contaC, zeraR, registraR, pronto, acertou, errou}, saidas(code));
   endtask

   task automatic step();
      @(negedge clock);
   endtask

   task automatic jogar(input logic ig, input logic fm);
      logic [3:0] esp;
      jogada = 1'b1;
      step();
      chk_estado("registra", 4'b0100);
      jogada = 1'b0; igual = ig; fim = fm;
      step();
      chk_estado("comparacao", 4'b0101);
      step();
      esp = !ig ? 4'b1110 : (fm ? 4'b1010 : 4'b0110);
      chk_estado("pos_comparacao", esp);
      if (contaC) n_conta++;
      if (ig && !fm) begin
         step();
         chk_estado("volta_espera", 4'b0010);
      end
      igual = 1'b0; fim = 1'b0;
   endtask

   task automatic iniciar_rodada();
      iniciar = 1'b1;
      step();
      chk_estado("preparacao", 4'b0001);
      iniciar = 1'b0;
      step();
      chk_estado("espera", 4'b0010);
   endtask

   initial begin
      reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fim = 1'b0;
      #1;
      chk_estado("reset_ativo", 4'b0000);
      step(); step();
      reset = 1'b0;
      step();
      chk_estado("pos_reset", 4'b0000);
      step();
      chk_estado("inicial_parado", 4'b0000);

      // Full success round
      iniciar_rodada();
      n_conta = 0;
      for (int i = 0; i < 16; i++) jogar(1'b1, (i == 15));
      chk("contaC_15", 7'(n_conta), 7'd15);
      step();
      chk_estado("fim_acertou_mantem", 4'b1010);

      // Restart from fim_acertou, then iniciar ignored in espera
      iniciar_rodada();
      iniciar = 1'b1;
      step();
      chk_estado("iniciar_em_espera", 4'b0010);
      iniciar = 1'b0;
      step();
      chk_estado("espera_estavel", 4'b0010);

      // Error on play 3
      n_conta = 0;
      jogar(1'b1, 1'b0);
      jogar(1'b1, 1'b0);
      jogar(1'b0, 1'b0);
      chk("contaC_2", 7'(n_conta), 7'd2);
      step();
      chk_estado("fim_errou_mantem", 4'b1110);

      // Button held from fim_errou through restart: no pulse in espera
      jogada = 1'b1;
      step();
      chk_estado("jogada_em_fim", 4'b1110);
      iniciar_rodada();
      for (int i = 0; i < 5; i++) step();
      chk_estado("jogada_presa_restart", 4'b0010);
      jogada = 1'b0;
      step();

      // Held button for 20 cycles in espera
      n_reg = 0;
      igual = 1'b1; fim = 1'b0;
      jogada = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (registraR) n_reg++;
      end
      chk("registraR_um_pulso", 7'(n_reg), 7'd1);
      chk_estado("botao_preso", 4'b0010);
      jogada = 1'b0; igual = 1'b0;
      step();

      // Asynchronous reset in registra
      jogada = 1'b1;
      step();
      chk_estado("antes_reset", 4'b0100);
      #2 reset = 1'b1;
      #1;
      chk_estado("reset_assincrono", 4'b0000);
      jogada = 1'b0;
      step();
      reset = 1'b0;
      step();
      chk_estado("pos_reset2", 4'b0000);
      iniciar = 1'b1;
      step();
      chk_estado("reinicio", 4'b0001);
      iniciar = 1'b0;
      step();
      chk_estado("zeraC_um_ciclo", 4'b0010);

      // Illegal state recovers to inicial
      force dut.r_estado = estado_t'(4'b1111);
      #1;
      release dut.r_estado;
      step();
      chk_estado("ilegal_recupera", 4'b0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Moore control unit for the Experiment 4 "sequence of plays" circuit. It sits directly upstream of the 4-bit modulo-16 address counter in the data path and drives its clear and count-enable signals. It also consumes the counter's terminal-count output (`fim`) and the data path's comparator result (`igual`). It sequences 16 button plays against memory contents and reports success or failure.

## Interface
Parameters:
- none; state encoding constants come from the shared package.

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces `inicial`.
- `iniciar`  in  1  start or restart request, level-sampled.
- `jogada`  in  1  OR of the play buttons, level; an internal rising-edge detector turns it into one event per press.
- `igual`  in  1  data-path comparator: registered play equals memory word.
- `fim`  in  1  counter terminal count (counter value 15 with `ent`=1).
- `zeraC`  out  1  synchronous clear request to the counter; active-high (the data path inverts it for the active-low `clr`).
- `contaC`  out  1  counter enable (drives `enp`; `ent` is tied high).
- `zeraR`  out  1  clear of the play register.
- `registraR`  out  1  load of the play register.
- `pronto`  out  1  round finished.
- `acertou`  out  1  round finished with all 16 plays correct.
- `errou`  out  1  round finished with a wrong play.
- `db_estado`  out  4  current state code, for the HEX display.

## Operation
- The unit is a pure Moore FSM: all outputs decode from the state register only.
- States and codes, with the outputs each state asserts:
  - `inicial` 0000: no outputs.
  - `preparacao` 0001: `zeraC`, `zeraR`.
  - `espera` 0010: no outputs.
  - `registra` 0100: `registraR`.
  - `comparacao` 0101: no outputs.
  - `proximo` 0110: `contaC`.
  - `fim_acertou` 1010: `pronto`, `acertou`.
  - `fim_errou` 1110: `pronto`, `errou`.
- Any other code recovers to `inicial` on the next edge.
- Transitions:
  - `inicial`: `iniciar`=1 → `preparacao`; otherwise stay.
  - `preparacao` → `espera` unconditionally.
  - `espera`: `jogada_pulso`=1 → `registra`; otherwise stay. `iniciar` is ignored.
  - `registra` → `comparacao` unconditionally.
  - `comparacao`:
    - `igual`=0 → `fim_errou`.
    - `igual`=1 and `fim`=1 → `fim_acertou`.
    - `igual`=1 and `fim`=0 → `proximo`.
  - `proximo` → `espera` unconditionally.
  - `fim_acertou` / `fim_errou`: `iniciar`=1 → `preparacao`; otherwise hold.
- Edge detector:
  - One flip-flop holds the previous sample of `jogada`.
  - `jogada_pulso` = `jogada` AND NOT previous sample.
  - A held button yields exactly one pulse; the button must be released and pressed again for the next pulse.
- The counter advances exactly once per correct, non-final play. Sixteen correct plays are required to reach `fim_acertou`.

## Timing
- Reset, asynchronous and immediate:
  - State goes to `inicial`; the edge-detector flip-flop is cleared to 0.
  - All outputs are 0 and `db_estado`=0000 while `reset` is high and in the first cycle after release.
- Reset mid-round (any state) aborts the round. The counter is not cleared until the next `preparacao`.
- `zeraC` and `zeraR` are high for exactly one cycle. The counter reads 0 after the edge that leaves `preparacao`.
- Latency of one play: `jogada` rises in cycle n while the FSM is in `espera`.
  - `registra` in cycle n+1.
  - `comparacao` in n+2.
  - `proximo` or `fim_*` in n+3.
  - Back in `espera` in n+4 for a correct play.
- `igual` and `fim` are sampled only in `comparacao`, one cycle after `registraR`, so the registered play value is stable.
- A `jogada` edge arriving in any state other than `espera` is consumed by the detector and produces no transition.
- If `jogada` is held from `fim_*` through restart, no pulse occurs in `espera` until it is released and pressed again.

## Structure
- Shared package `exp4_pkg` holds:
  - the 4-bit state code constants, named as in Operation;
  - the width constant `ESTADO_W`=4.
- Sub-module `edge_detector` (inputs `clock`, `reset`, `sinal`; output `pulso`), using the same reset convention. It is reused by later experiments.
- Body: state register, next-state logic, and output decode. Roughly 150 lines in total.

## Test plan
- Full success: reset, `iniciar` pulse, then 16 press/release cycles with `igual`=1 and `fim`=1 on the 16th. Required: `contaC` pulses 15 times, then `pronto`=`acertou`=1, `errou`=0, `db_estado`=1010.
- Error on play 3: `igual`=0 at the third comparison. Required: `fim_errou` (1110) 3 cycles after that press, `pronto`=`errou`=1, `contaC` pulsed only twice.
- Held button: `jogada` held high for 20 cycles in `espera`. Required: exactly one `registraR` pulse, and the FSM returns to `espera` and stays there.
- Asynchronous reset asserted mid-`registra`. Required: `db_estado`=0000 and all outputs 0 immediately, before the next clock edge; `iniciar` then restarts normally with a one-cycle `zeraC`.
- `iniciar` pulsed while in `espera`: no state change. `iniciar` asserted in `fim_acertou`: `preparacao` on the next edge, with `zeraC`=`zeraR`=1 for one cycle.
- Illegal state forced via `$deposit` (code 1111). Required: `inicial` on the next edge.
